imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 33 +++
 rtl/imem_arbiter.sv | 84 ++++++++
 tb/tb_imem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-port signals shared by imem_arbiter and its environment.
// Requesters and memory connect through master; the arbiter connects through slave.
interface imem_arbiter_if;
  logic        FetchReq;
  logic [15:0] FetchAddr;
  logic [31:0] FetchData;
  logic        FetchValid;
  logic        FetchEn;
  logic        LdReq;
  logic        LdWe;
  logic [15:0] LdAddr;
  logic [31:0] LdWData;
  logic [31:0] LdRData;
  logic        LdAck;
  logic        MemEn;
  logic        MemWe;
  logic [15:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        GrantLd;

  modport slave (
    input  FetchReq, FetchAddr, LdReq, LdWe, LdAddr, LdWData, MemRData,
    output FetchData, FetchValid, FetchEn, LdRData, LdAck,
           MemEn, MemWe, MemAddr, MemWData, GrantLd
  );

  modport master (
    output FetchReq, FetchAddr, LdReq, LdWe, LdAddr, LdWData, MemRData,
    input  FetchData, FetchValid, FetchEn, LdRData, LdAck,
           MemEn, MemWe, MemAddr, MemWData, GrantLd
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for one single-port sync IMEM; optional starvation guard via IMEM_ARB_STARVE_GUARD_EN.
// Grant is combinational in cycle N, response 1 cycle later; losing fetch is stalled with FetchEn=0, loader holds LdReq.
module imem_arbiter (
  input  logic           Clock,
  input  logic           nReset,
  imem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {NONE, FETCH, LOAD} state_t;

  state_t state;
  logic   ld_we_q;
  logic   ld_elig;
  logic   force_ld;
  logic   ld_win;
  logic   fetch_win;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_ld = ld_elig && (starve_cnt == 3'd7);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      starve_cnt <= 3'd0;
    end else if (ld_win || !bus.LdReq) begin
      starve_cnt <= 3'd0;
    end else if (ld_elig && fetch_win && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign force_ld = 1'b0;
`endif

  // Grants are gated by nReset so a transaction in flight at reset never reaches memory.
  always_comb begin
    ld_elig   = nReset && bus.LdReq && (state != LOAD);
    ld_win    = ld_elig && (!bus.FetchReq || force_ld);
    fetch_win = nReset && bus.FetchReq && !ld_win;
  end

  always_comb begin
    bus.MemEn    = fetch_win || ld_win;
    bus.MemWe    = ld_win && bus.LdWe;
    bus.MemAddr  = 16'h0000;
    bus.MemWData = 32'h0000_0000;
    if (fetch_win) begin
      bus.MemAddr = bus.FetchAddr;
    end else if (ld_win) begin
      bus.MemAddr  = bus.LdAddr;
      bus.MemWData = bus.LdWData;
    end
    bus.GrantLd = ld_win;
    bus.FetchEn = !nReset || !(bus.FetchReq && !fetch_win);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= NONE;
      ld_we_q <= 1'b0;
    end else begin
      if (fetch_win) begin
        state <= FETCH;
      end else if (ld_win) begin
        state <= LOAD;
      end else begin
        state <= NONE;
      end
      if (ld_win) begin
        ld_we_q <= bus.LdWe;
      end
    end
  end

  // Read data is only forwarded to the owner of the previous cycle's grant.
  always_comb begin
    bus.FetchValid = (state == FETCH);
    bus.LdAck      = (state == LOAD);
    bus.FetchData  = bus.FetchValid ? bus.MemRData : 32'h0000_0000;
    bus.LdRData    = (bus.LdAck && !ld_we_q) ? bus.MemRData : 32'h0000_0000;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a reference arbitration model checks every cycle,
// expected responses are queued at grant time and popped when the response cycle arrives.
module tb_imem_arbiter;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic Clock;
  logic nReset;
  imem_arbiter_if bus ();

  imem_arbiter dut (.Clock(Clock), .nReset(nReset), .bus(bus));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Environment memory: stores data XOR a per-address pattern so unwritten words read non-zero.
  bit [31:0] mem [256];
  bit [31:0] rdata_q;
  always @(posedge Clock) begin
    if (bus.MemEn) begin
      if (bus.MemWe) mem[bus.MemAddr[7:0]] <= bus.MemWData ^ pat(bus.MemAddr);
      else           rdata_q <= mem[bus.MemAddr[7:0]] ^ pat(bus.MemAddr);
    end
  end
  assign bus.MemRData = rdata_q;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {~a, a};
  endfunction

  typedef struct {
    bit          is_ld;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  bit [31:0]   ref_mem [256];
  bit          pw_vld;
  logic [15:0] pw_addr;
  logic [31:0] pw_dat;
  bit          m_ld_state;
  int          m_cnt;
  int          cyc, last_gnt_cyc, ack_cyc;
  int          men_cnt, gnt_cnt, ack_cnt;
  bit          ack_seen;
  logic [31:0] ld_rd_last;
  int          checks, failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem[a[7:0]] ^ pat(a);
  endfunction

  task automatic sample();
    rsp_t        r;
    bit          elig, frc, lg, fg;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    @(negedge Clock);
    if (pw_vld) begin
      ref_mem[pw_addr[7:0]] = pw_dat ^ pat(pw_addr);
      pw_vld = 1'b0;
    end
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("fetch_valid", {31'b0, bus.FetchValid}, {31'b0, !r.is_ld});
      chk("ld_ack", {31'b0, bus.LdAck}, {31'b0, r.is_ld});
      if (r.is_ld) chk("ld_rdata", bus.LdRData, r.data);
      else         chk("fetch_data", bus.FetchData, r.data);
    end else begin
      chk("fetch_valid_idle", {31'b0, bus.FetchValid}, 32'd0);
      chk("ld_ack_idle", {31'b0, bus.LdAck}, 32'd0);
    end
    if (bus.LdAck) begin
      ack_seen = 1'b1;
      ack_cnt++;
      ack_cyc = cyc;
      ld_rd_last = bus.LdRData;
    end
    elig   = bus.LdReq && !m_ld_state;
    frc    = GUARD && (m_cnt == 7) && elig;
    lg     = elig && (!bus.FetchReq || frc);
    fg     = bus.FetchReq && !lg;
    e_addr = fg ? bus.FetchAddr : (lg ? bus.LdAddr : 16'h0);
    e_wd   = lg ? bus.LdWData : 32'h0;
    chk("mem_en", {31'b0, bus.MemEn}, {31'b0, lg | fg});
    chk("mem_we", {31'b0, bus.MemWe}, {31'b0, lg & bus.LdWe});
    chk("mem_addr", {16'b0, bus.MemAddr}, {16'b0, e_addr});
    chk("mem_wdata", bus.MemWData, e_wd);
    chk("grant_ld", {31'b0, bus.GrantLd}, {31'b0, lg});
    chk("fetch_en", {31'b0, bus.FetchEn}, {31'b0, !(bus.FetchReq && !fg)});
    if (bus.MemEn) men_cnt++;
    if (bus.GrantLd) begin
      gnt_cnt++;
      last_gnt_cyc = cyc;
    end
    if (fg) sb.push_back('{is_ld: 1'b0, data: ref_read(bus.FetchAddr)});
    if (lg) sb.push_back('{is_ld: 1'b1, data: bus.LdWe ? 32'h0 : ref_read(bus.LdAddr)});
    if (lg && bus.LdWe) begin
      pw_vld  = 1'b1;
      pw_addr = bus.LdAddr;
      pw_dat  = bus.LdWData;
    end
    if (lg || !bus.LdReq) m_cnt = 0;
    else if (elig && fg && m_cnt < 7) m_cnt++;
    m_ld_state = lg;
    cyc++;
  endtask

  task automatic advance();
    @(posedge Clock);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // Loader transaction: LdReq held until LdAck, with a bounded wait.
  task automatic ld_txn(input bit we, input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    bus.LdReq = 1'b1; bus.LdWe = we; bus.LdAddr = a; bus.LdWData = wd;
    ack_seen = 1'b0;
    for (int k = 0; k < 20 && !ack_seen; k++) cycle();
    if (!ack_seen) chk("ld_timeout", 32'd0, 32'd1);
    bus.LdReq = 1'b0; bus.LdWe = 1'b0;
    rd  = ld_rd_last;
    lat = ack_cyc - last_gnt_cyc;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          first_idx;
    checks = 0; failures = 0; cyc = 0;
    pw_vld = 1'b0; m_ld_state = 1'b0; m_cnt = 0;
    nReset = 1'b0;
    bus.FetchReq = 1'b1; bus.FetchAddr = 16'h0005;
    bus.LdReq = 1'b1; bus.LdWe = 1'b1; bus.LdAddr = 16'h0001; bus.LdWData = 32'h1;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_mem_en", {31'b0, bus.MemEn}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.MemWe}, 32'd0);
    chk("rst_grant_ld", {31'b0, bus.GrantLd}, 32'd0);
    chk("rst_fetch_en", {31'b0, bus.FetchEn}, 32'd1);
    chk("rst_fetch_valid", {31'b0, bus.FetchValid}, 32'd0);
    chk("rst_ld_ack", {31'b0, bus.LdAck}, 32'd0);
    chk("rst_fetch_data", bus.FetchData, 32'd0);
    chk("rst_ld_rdata", bus.LdRData, 32'd0);
    bus.FetchReq = 1'b0; bus.LdReq = 1'b0; bus.LdWe = 1'b0;
    nReset = 1'b1;
    advance();

    // Fetch stream 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      bus.FetchReq = 1'b1; bus.FetchAddr = 16'(i);
      cycle();
    end
    bus.FetchReq = 1'b0;
    cycle();

    // Loader write then read-back
    ld_txn(1'b1, 16'h0010, 32'hDEAD_BEEF, rd, lat);
    chk("ld_wr_latency", lat, 32'd1);
    ld_txn(1'b0, 16'h0010, 32'h0, rd, lat);
    chk("ld_rd_data", rd, 32'hDEAD_BEEF);
    cycle();

    // Held LdReq: one access per two cycles
    bus.LdReq = 1'b1; bus.LdWe = 1'b0; bus.LdAddr = 16'h0010;
    men_cnt = 0;
    repeat (8) cycle();
    chk("held_mem_en_count", men_cnt, 32'd4);
    bus.LdReq = 1'b0;
    cycle();

    // Contention: both requesters held
    bus.LdReq = 1'b1; bus.LdWe = 1'b0; bus.LdAddr = 16'h0003;
    gnt_cnt = 0; ack_cnt = 0; first_idx = -1;
    for (int i = 0; i < 40; i++) begin
      bus.FetchReq = 1'b1; bus.FetchAddr = 16'(16'h0040 + i);
      sample();
      if (bus.GrantLd && first_idx < 0) first_idx = i;
      advance();
    end
    chk("first_ld_grant", first_idx, GUARD ? 32'd7 : 32'hFFFF_FFFF);
    chk("ld_granted", {31'b0, gnt_cnt != 0}, {31'b0, GUARD});
    chk("ld_ack_any", {31'b0, ack_cnt != 0}, {31'b0, GUARD});
    bus.FetchReq = 1'b0; bus.LdReq = 1'b0;
    cycle();

    // Reset pulsed in the loader-grant cycle
    bus.LdReq = 1'b1; bus.LdWe = 1'b1; bus.LdAddr = 16'h0020; bus.LdWData = 32'h1234_5678;
    sample();
    chk("rst_mid_grant", {31'b0, bus.GrantLd}, 32'd1);
    #1 nReset = 1'b0;
    sb.delete(); pw_vld = 1'b0; m_ld_state = 1'b0; m_cnt = 0;
    #1;
    chk("rst_mid_mem_en", {31'b0, bus.MemEn}, 32'd0);
    chk("rst_mid_ld_ack", {31'b0, bus.LdAck}, 32'd0);
    advance();
    chk("rst_mid_ld_ack_hold", {31'b0, bus.LdAck}, 32'd0);
    chk("rst_mid_fetch_valid", {31'b0, bus.FetchValid}, 32'd0);
    nReset = 1'b1;
    ld_txn(1'b1, 16'h0020, 32'h1234_5678, rd, lat);
    chk("retry_latency", lat, 32'd1);
    ld_txn(1'b0, 16'h0020, 32'h0, rd, lat);
    chk("retry_readback", rd, 32'h1234_5678);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
